// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e    : FSM state encoding (IDLE/RD/WR/DONE)
//   F3_*           : RISC-V funct3 codes for access size/sign
//   BYTE_W/HALF_W  : lane widths
//   f3_legal()     : funct3 legality for loads vs stores
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake between core and LSU.
//   Request : iReq, iWe, iFunct3, iAddr, iWData   (core -> LSU)
//   Response: oBusy, oDone, oFault, oRData        (LSU -> core)
//   master = core side, slave = LSU side.
interface load_store_unit_if;
  logic        iReq;
  logic        iWe;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy;
  logic        oDone;
  logic        oFault;
  logic [31:0] oRData;

  modport master (
    output iReq, iWe, iFunct3, iAddr, iWData,
    input  oBusy, oDone, oFault, oRData
  );

  modport slave (
    input  iReq, iWe, iFunct3, iAddr, iWData,
    output oBusy, oDone, oFault, oRData
  );
endinterface

// File: rtl/lsu_lane_unit.sv
// lsu_lane_unit: combinational byte/half lane handling.
//   funct3_i : access size/sign
//   lane_i   : byte address low bits (half uses lane_i[1])
//   rword_i  : memory word for load extraction
//   old_i    : previously read word for sub-word store merge
//   wdata_i  : store data (low byte/half used)
//   load_o   : extracted and extended load value
//   merge_o  : old_i with the addressed byte/half replaced
module lsu_lane_unit
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  always_comb begin
    byte_v = rword_i[7:0];
    case (lane_i)
      2'd1:    byte_v = rword_i[15:8];
      2'd2:    byte_v = rword_i[23:16];
      2'd3:    byte_v = rword_i[31:24];
      default: ;
    endcase
    half_v = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

    case (funct3_i)
      F3_B:    load_o = {{(32-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
      F3_H:    load_o = {{(32-HALF_W){half_v[HALF_W-1]}}, half_v};
      F3_BU:   load_o = {{(32-BYTE_W){1'b0}}, byte_v};
      F3_HU:   load_o = {{(32-HALF_W){1'b0}}, half_v};
      default: load_o = rword_i;
    endcase
  end

  always_comb begin
    merge_o = old_i;
    if (funct3_i == F3_B) begin
      case (lane_i)
        2'd0:    merge_o[7:0]   = wdata_i[7:0];
        2'd1:    merge_o[15:8]  = wdata_i[7:0];
        2'd2:    merge_o[23:16] = wdata_i[7:0];
        default: merge_o[31:24] = wdata_i[7:0];
      endcase
    end else if (funct3_i == F3_H) begin
      if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
      else           merge_o[15:0]  = wdata_i[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes RISC-V lb/lh/lw/lbu/lhu/sb/sh/sw against a
// word-wide data memory with combinational read and edge-triggered write.
// Sub-word stores are read-modify-write.
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   bus          : core handshake (load_store_unit_if.slave)
//   iDado        : memory read data (combinational from oEnd/oLeMem)
//   oEnd         : word-aligned memory byte address
//   oDadoEscrita : memory write data
//   oEscMem      : memory write enable
//   oLeMem       : memory read enable
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise the low address bits are masked to the access size.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  load_store_unit_if.slave    bus,
  input  logic [31:0]         iDado,
  output logic [31:0]         oEnd,
  output logic [31:0]         oDadoEscrita,
  output logic                oEscMem,
  output logic                oLeMem
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rmw_q, rmw_d;
  logic        fault_q, fault_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misalign;
  logic        req_fault;
  logic [31:0] addr_masked;
  logic [31:0] load_val;
  logic [31:0] merged;

  lsu_lane_unit u_lane (
    .funct3_i (f3_q),
    .lane_i   (addr_q[1:0]),
    .rword_i  (iDado),
    .old_i    (merge_q),
    .wdata_i  (wdata_q),
    .load_o   (load_val),
    .merge_o  (merged)
  );

  // Request qualification; the masked address keeps the lane selection
  // naturally aligned when misalignment is not trapped.
  always_comb begin
    misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.iFunct3[1:0])
      2'b01:   misalign = bus.iAddr[0];
      2'b10:   misalign = |bus.iAddr[1:0];
      default: ;
    endcase
`endif
    req_fault = !f3_legal(bus.iWe, bus.iFunct3) ||
                ({1'b0, bus.iAddr} >= ADDR_LIMIT) || misalign;
    addr_masked = bus.iAddr;
    case (bus.iFunct3[1:0])
      2'b01:   addr_masked[0]   = 1'b0;
      2'b10:   addr_masked[1:0] = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rmw_q   <= 1'b0;
      fault_q <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rmw_q   <= rmw_d;
      fault_q <= fault_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.iReq) begin
        if (req_fault)                        state_d = DONE;
        else if (bus.iWe && bus.iFunct3 == F3_W) state_d = WR;
        else                                  state_d = RD;
      end
      RD:      state_d = rmw_q ? WR : DONE;
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rmw_d   = rmw_q;
    fault_d = fault_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.iReq) begin
        addr_d  = addr_masked;
        wdata_d = bus.iWData;
        f3_d    = bus.iFunct3;
        fault_d = req_fault;
        rmw_d   = bus.iWe && (bus.iFunct3 != F3_W);
      end
      RD: begin
        if (rmw_q) merge_d = iDado;
        else       rdata_d = load_val;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.oBusy    = (state_q != IDLE);
    bus.oDone    = (state_q == DONE);
    bus.oFault   = (state_q == DONE) && fault_q;
    bus.oRData   = rdata_q;
    oLeMem       = (state_q == RD);
    oEscMem      = (state_q == WR);
    oEnd         = '0;
    oDadoEscrita = '0;
    if (state_q == RD || state_q == WR) oEnd = {addr_q[31:2], 2'b00};
    if (state_q == WR) oDadoEscrita = rmw_q ? merged : wdata_q;
  end

endmodule
